// File: rtl/add_rr_arbiter.sv
// Round-robin burst arbiter: drains NUM_IN add_fifo heads onto one registered
// valid/ready channel, holding each grant for up to MAX_BURST words.
module add_rr_arbiter #(
    parameter int NUM_IN     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         arb_en,
    input  logic [NUM_IN-1:0]            fifo_empty,
    input  logic [NUM_IN*DATA_WIDTH-1:0] fifo_data,
    output logic [NUM_IN-1:0]            fifo_rd,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [$clog2(NUM_IN)-1:0]    out_src,
    output logic                         busy
);
    localparam int IDX_W = $clog2(NUM_IN);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_IN - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]        grant, grant_nxt, grant_inc;
    logic [CNT_W-1:0]        beat_cnt, beat_cnt_nxt;
    logic [IDX_W-1:0]        sel_idx, sel_hi, sel_lo;
    logic                    sel_found, hi_found;
    logic                    can_load, head_empty, pop;
    logic [DATA_WIDTH-1:0]   head_data;

    assign can_load  = !out_valid || out_ready;
    assign pop       = rst_n && (state == BURST) && can_load && !head_empty;
    assign grant_inc = (grant == LAST_IDX) ? '0 : grant + IDX_W'(1);
    assign busy      = (state == BURST);

    // Head of the granted FIFO, selected by comparison so no variable slicing is needed.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        head_empty = 1'b1;
        head_data  = '0;
        fifo_rd    = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant == IDX_W'(i)) begin
                head_empty = fifo_empty[i];
                head_data  = fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
                fifo_rd[i] = pop;
            end
        end
    end

    // Round-robin pick: lowest requester at or above rr_ptr, else lowest overall.
    always_comb begin
        sel_hi    = '0;
        sel_lo    = '0;
        hi_found  = 1'b0;
        sel_found = 1'b0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (!fifo_empty[i]) begin
                sel_lo    = IDX_W'(i);
                sel_found = 1'b1;
                if (IDX_W'(i) >= rr_ptr) begin
                    sel_hi   = IDX_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        sel_idx = hi_found ? sel_hi : sel_lo;
    end

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        grant_nxt    = grant;
        beat_cnt_nxt = beat_cnt;
        unique case (state)
            IDLE: begin
                if (arb_en && sel_found) begin
                    grant_nxt    = sel_idx;
                    beat_cnt_nxt = '0;
                    state_nxt    = BURST;
                end
            end
            BURST: begin
                if (head_empty) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = grant_inc;
                end else if (pop) begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                    if (beat_cnt == LAST_BEAT) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = grant_inc;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            grant    <= grant_nxt;
            beat_cnt <= beat_cnt_nxt;
            if (pop) begin
                out_data  <= head_data;
                out_src   <= grant;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_add_rr_arbiter.sv
// Bench for add_rr_arbiter: bench-owned FIFO queues, a transaction-level model
// checked every cycle, and per-source ordering of delivered words.
module tb_add_rr_arbiter;
    localparam int NUM_IN    = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;
    localparam int QDEPTH    = 16;

    logic                 clk = 1'b0;
    logic                 rst_n, arb_en, out_ready;
    logic [NUM_IN-1:0]    fifo_empty, fifo_rd;
    logic [NUM_IN*DW-1:0] fifo_data;
    logic                 out_valid, busy;
    logic [DW-1:0]        out_data;
    logic [1:0]           out_src;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0]     q[NUM_IN][$];
    logic [DW-1:0]     gold[NUM_IN][$];
    logic [NUM_IN-1:0] trace[$];

    bit            m_burst, m_ov, m_pop, m_head_empty;
    int            m_rr, m_grant, m_beats, m_os;
    logic [DW-1:0] m_od;

    logic [NUM_IN-1:0] s_rd;
    logic              s_ov, s_busy;
    logic [DW-1:0]     s_od;
    logic [1:0]        s_os;

    add_rr_arbiter #(.NUM_IN(NUM_IN), .DATA_WIDTH(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_src(out_src), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int src, input logic [DW-1:0] w);
        q[src].push_back(w);
        gold[src].push_back(w);
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NUM_IN; i++)
            if (q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int onehot_idx(input logic [NUM_IN-1:0] v);
        int r = -1;
        for (int i = 0; i < NUM_IN; i++)
            if (v[i]) r = i;
        return r;
    endfunction

    function automatic int trace_pops();
        int n = 0;
        foreach (trace[i])
            if (trace[i] != '0) n++;
        return n;
    endfunction

    task automatic drive_fifos();
        for (int i = 0; i < NUM_IN; i++) begin
            fifo_empty[i] = (q[i].size() == 0);
            fifo_data[i*DW +: DW] = (q[i].size() > 0) ? q[i][0] : '0;
        end
    endtask

    // Model advance on one clock edge, from the abstract rules of the arbiter.
    task automatic model_edge();
        logic [DW-1:0] tmp;
        bit found;
        if (!rst_n) begin
            if (m_ov && gold[m_os].size() > 0) tmp = gold[m_os].pop_front();
            m_burst = 0; m_ov = 0; m_rr = 0; m_grant = 0; m_beats = 0; m_od = '0; m_os = 0;
            return;
        end
        if (m_pop) begin
            m_od = q[m_grant].pop_front();
            m_os = m_grant;
            m_ov = 1;
        end else if (m_ov && out_ready) begin
            m_ov = 0;
        end
        if (!m_burst) begin
            found = 0;
            if (arb_en) begin
                for (int k = 0; k < NUM_IN; k++) begin
                    int idx;
                    idx = (m_rr + k) % NUM_IN;
                    if (!found && q[idx].size() > 0) begin
                        found   = 1;
                        m_grant = idx;
                    end
                end
            end
            if (found) begin
                m_burst = 1;
                m_beats = 0;
            end
        end else if (m_head_empty) begin
            m_burst = 0;
            m_rr    = (m_grant + 1) % NUM_IN;
        end else if (m_pop) begin
            m_beats++;
            if (m_beats == MAX_BURST) begin
                m_burst = 0;
                m_rr    = (m_grant + 1) % NUM_IN;
            end
        end
    endtask

    task automatic cycle();
        logic [NUM_IN-1:0] exp_rd;
        logic [DW-1:0]     exp_w;
        drive_fifos();
        @(negedge clk);
        s_rd = fifo_rd; s_ov = out_valid; s_od = out_data; s_os = out_src; s_busy = busy;
        m_head_empty = m_burst && (q[m_grant].size() == 0);
        m_pop  = rst_n && m_burst && (!m_ov || out_ready) && !m_head_empty;
        exp_rd = m_pop ? (NUM_IN'(1) << m_grant) : '0;
        check("fifo_rd", s_rd, exp_rd);
        check("out_valid", s_ov, m_ov);
        check("out_data", s_od, m_od);
        check("out_src", s_os, m_os);
        check("busy", s_busy, m_burst);
        if (rst_n && s_ov && out_ready) begin
            if (gold[s_os].size() == 0) begin
                total++; bad++;
                $display("FAIL delivery: got 0x%0h from src %0d, expected no word pending", s_od, s_os);
            end else begin
                exp_w = gold[s_os].pop_front();
                check("delivery_order", s_od, exp_w);
            end
        end
        @(posedge clk);
        model_edge();
        #1;
        trace.push_back(s_rd);
    endtask

    task automatic do_reset();
        rst_n = 0;
        cycle();
        rst_n = 1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        rst_n = 1; arb_en = 1; out_ready = 1;
        while ((!all_empty() || m_ov || m_burst) && n < 400) begin
            cycle();
            n++;
        end
        check({"drain_done_", tag}, (n < 400), 1);
        for (int i = 0; i < NUM_IN; i++)
            check({"all_delivered_", tag}, gold[i].size(), 0);
    endtask

    task automatic analyze_rotation();
        int run_src[$];
        int run_len[$];
        int gaps[$];
        int cur = 0;
        int gap = 0;
        bit seen = 0;
        foreach (trace[i]) begin
            if (trace[i] != '0) begin
                if (cur == 0) begin
                    run_src.push_back(onehot_idx(trace[i]));
                    if (seen) gaps.push_back(gap);
                end
                cur++;
                gap = 0;
            end else begin
                if (cur > 0) begin
                    run_len.push_back(cur);
                    seen = 1;
                    cur = 0;
                end
                gap++;
            end
        end
        if (cur > 0) run_len.push_back(cur);
        check("t3_num_bursts", run_src.size(), 8);
        foreach (run_src[i]) check("t3_grant_order", run_src[i], i % NUM_IN);
        foreach (run_len[i]) check("t3_burst_len", run_len[i], MAX_BURST);
        foreach (gaps[i]) check("t3_bubble", gaps[i], 1);
    endtask

    initial begin
        rst_n = 0; arb_en = 1; out_ready = 1;
        fifo_empty = '1; fifo_data = '0;
        m_burst = 0; m_ov = 0; m_rr = 0; m_grant = 0; m_beats = 0; m_od = '0; m_os = 0;
        m_pop = 0; m_head_empty = 0;
        @(posedge clk);
        #1;

        // 1: reset with every FIFO non-empty; first grant after release is FIFO 0.
        for (int i = 0; i < NUM_IN; i++) push(i, 8'(8'h50 + i));
        repeat (3) cycle();
        check("t1_rd_in_reset", s_rd, 0);
        rst_n = 1;
        cycle();
        check("t1_idle_rd", s_rd, 0);
        cycle();
        check("t1_first_grant", s_rd, 4'b0001);
        drain("t1");

        // 2: single source FIFO1 with three words.
        do_reset();
        push(1, 8'h11); push(1, 8'h22); push(1, 8'h33);
        cycle(); check("t2_c0_rd", s_rd, 0);
        cycle(); check("t2_c1_rd", s_rd, 4'b0010);
        cycle(); check("t2_c2_rd", s_rd, 4'b0010); check("t2_c2_data", s_od, 8'h11);
                 check("t2_c2_src", s_os, 1); check("t2_c2_valid", s_ov, 1);
        cycle(); check("t2_c3_rd", s_rd, 4'b0010); check("t2_c3_data", s_od, 8'h22);
        cycle(); check("t2_c4_rd", s_rd, 0); check("t2_c4_data", s_od, 8'h33);
                 check("t2_c4_busy", s_busy, 1);
        cycle(); check("t2_c5_busy", s_busy, 0); check("t2_c5_valid", s_ov, 0);
        push(0, 8'h01); push(2, 8'h02);
        cycle();
        cycle(); check("t2_next_grant_from_ptr2", s_rd, 4'b0100);
        drain("t2");

        // 3: all four FIFOs hold eight words.
        do_reset();
        trace.delete();
        for (int i = 0; i < NUM_IN; i++)
            for (int k = 0; k < 8; k++) push(i, 8'(i * 16 + k));
        drain("t3");
        analyze_rotation();

        // 4: backpressure after the second word of a burst.
        do_reset();
        trace.delete();
        for (int k = 0; k < 4; k++) push(0, 8'(8'hA0 + k));
        repeat (3) cycle();
        out_ready = 0;
        repeat (5) begin
            cycle();
            check("t4_stall_rd", s_rd, 0);
            check("t4_stall_valid", s_ov, 1);
            check("t4_stall_data", s_od, 8'hA1);
        end
        drain("t4");
        check("t4_total_pops", trace_pops(), 4);

        // 5: arb_en gating.
        do_reset();
        arb_en = 0;
        for (int k = 0; k < 6; k++) push(2, 8'(8'hC0 + k));
        repeat (10) begin
            cycle();
            check("t5_disabled_rd", s_rd, 0);
        end
        trace.delete();
        arb_en = 1;
        cycle(); check("t5_grant_cycle_rd", s_rd, 0);
        cycle(); check("t5_first_pop", s_rd, 4'b0100);
        arb_en = 0;
        repeat (12) cycle();
        check("t5_burst_pops", trace_pops(), MAX_BURST);
        check("t5_idle_after", s_busy, 0);
        drain("t5");

        // 6: reset after the second pop of a FIFO3 burst.
        do_reset();
        for (int k = 0; k < 4; k++) push(3, 8'(8'h30 + k));
        cycle();
        cycle(); check("t6_pop1", s_rd, 4'b1000);
        cycle(); check("t6_pop2", s_rd, 4'b1000);
        rst_n = 0; out_ready = 0;
        push(1, 8'h10); push(1, 8'h11);
        cycle(); check("t6_rd_in_reset", s_rd, 0);
        rst_n = 1; out_ready = 1;
        cycle(); check("t6_valid_cleared", s_ov, 0); check("t6_idle", s_busy, 0);
        cycle(); check("t6_scan_from_0", s_rd, 4'b0010);
        drain("t6");

        // Random traffic, backpressure, arb_en toggles and rare resets.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) != 0) begin
                int s;
                s = $urandom_range(0, NUM_IN - 1);
                if (q[s].size() < QDEPTH) push(s, 8'($urandom));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            arb_en    = ($urandom_range(0, 7) != 0);
            rst_n     = ($urandom_range(0, 499) != 0);
            cycle();
        end
        drain("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
